// File: rtl/net_router_flattened_pkg.sv
// net_router_flattened_pkg: shared packet type, widths and destination decode helper
package net_router_flattened_pkg;

    localparam int mask_length_gp = 8;
    localparam int net_router_cnt_width_gp = 16;

    typedef struct packed {
        logic                      valid;
        logic [mask_length_gp-1:0] ID;
        logic [15:0]               data;
    } net_packet_s;

    // Index of the lowest set ID bit; mask_length_gp when no bit is set
    function automatic int lowest_set(input logic [mask_length_gp-1:0] id);
        lowest_set = mask_length_gp;
        for (int b = mask_length_gp - 1; b >= 0; b--)
            if (id[b]) lowest_set = b;
    endfunction

endpackage

// File: rtl/net_fifo.sv
// net_fifo: per-source packet FIFO, accepts a write when full if it pops in the same cycle
module net_fifo #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enq,
    input  logic             deq,
    input  logic [width-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [width-1:0] head
);
    localparam int aw = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [aw-1:0]    rd_ptr, wr_ptr;
    logic [aw:0]      count;
    logic             do_enq, do_deq;

    assign do_deq = deq && !empty;
    assign do_enq = enq && (!full || do_deq);
    assign full   = count == (aw + 1)'(depth);
    assign empty  = count == '0;
    assign head   = mem[rd_ptr];

    // Storage array; contents are don't-care while empty so it needs no reset
    always_ff @(posedge clk)
        if (do_enq) mem[wr_ptr] <= din;

    // Pointers and occupancy; pointers wrap naturally since depth is a power of two
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) wr_ptr <= wr_ptr + 1'b1;
            if (do_deq) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (aw + 1)'(do_enq) - (aw + 1)'(do_deq);
        end

endmodule

// File: rtl/net_router_flattened.sv
// net_router_flattened: buffered round-robin packet router between flattened cores
module net_router_flattened
    import net_router_flattened_pkg::*;
#(
    parameter int num_cores_p  = 4,
    parameter int fifo_depth_p = 4,
    localparam int pkt_w_lp    = $bits(net_packet_s)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [num_cores_p*pkt_w_lp-1:0] core_packet_flat_i,
    output logic [num_cores_p*pkt_w_lp-1:0] core_packet_flat_o,
    output logic [15:0]                     drop_count_o,
    output logic [15:0]                     misroute_count_o,
    output logic                            busy_o
);
    localparam int iw = num_cores_p > 1 ? $clog2(num_cores_p) : 1;
    localparam int cw = net_router_cnt_width_gp;

    net_packet_s            in_pkt   [num_cores_p];
    net_packet_s            head_pkt [num_cores_p];
    logic [iw-1:0]          head_dest[num_cores_p];
    logic [iw-1:0]          gnt_idx  [num_cores_p];
    logic [num_cores_p-1:0] in_ok, misroute, full, empty, deq, drop, gnt_vld, out_vld;
    logic [cw:0]            drop_sum, mis_sum;

    for (genvar i = 0; i < num_cores_p; i++) begin : g_src
        logic pop;
        assign in_pkt[i]    = core_packet_flat_i[i*pkt_w_lp +: pkt_w_lp];
        assign in_ok[i]     = in_pkt[i].valid && lowest_set(in_pkt[i].ID) < num_cores_p;
        assign misroute[i]  = in_pkt[i].valid && !in_ok[i];
        assign drop[i]      = in_ok[i] && full[i] && !pop;
        assign deq[i]       = pop;
        assign head_dest[i] = iw'(lowest_set(head_pkt[i].ID));

        // A FIFO pops when whichever output its head targets grants it
        always_comb begin
            pop = 1'b0;
            for (int j = 0; j < num_cores_p; j++)
                if (gnt_vld[j] && gnt_idx[j] == iw'(i)) pop = 1'b1;
        end

        net_fifo #(.width(pkt_w_lp), .depth(fifo_depth_p)) u_fifo (
            .clk    (clk),
            .reset_n(reset_n),
            .enq    (in_ok[i]),
            .deq    (deq[i]),
            .din    (in_pkt[i]),
            .full   (full[i]),
            .empty  (empty[i]),
            .head   (head_pkt[i])
        );
    end

    for (genvar j = 0; j < num_cores_p; j++) begin : g_dst
        logic [num_cores_p-1:0] req;
        logic                   vld;
        logic [iw-1:0]          idx, rr;
        net_packet_s            out_q;
        assign gnt_vld[j] = vld;
        assign gnt_idx[j] = idx;
        assign out_vld[j] = out_q.valid;
        assign core_packet_flat_o[j*pkt_w_lp +: pkt_w_lp] = out_q;

        // Search requesters starting at the round-robin pointer, wrapping around
        always_comb begin
            vld = 1'b0;
            idx = rr;
            for (int i = 0; i < num_cores_p; i++) req[i] = !empty[i] && head_dest[i] == iw'(j);
            for (int k = 0; k < num_cores_p; k++)
                if (!vld && req[(int'(rr) + k) % num_cores_p]) begin
                    vld = 1'b1;
                    idx = iw'((int'(rr) + k) % num_cores_p);
                end
        end

        // Advance the pointer past the winner and register the granted head
        always_ff @(posedge clk or negedge reset_n)
            if (!reset_n) begin
                rr    <= '0;
                out_q <= '0;
            end else begin
                if (vld) rr <= idx == iw'(num_cores_p - 1) ? '0 : idx + 1'b1;
                out_q <= vld ? head_pkt[idx] : '0;
            end
    end

    // Add all of this cycle's drop events to the current counts, one bit wider to catch overflow
    always_comb begin
        drop_sum = {1'b0, drop_count_o};
        mis_sum  = {1'b0, misroute_count_o};
        for (int i = 0; i < num_cores_p; i++) begin
            drop_sum = drop_sum + (cw + 1)'(drop[i]);
            mis_sum  = mis_sum + (cw + 1)'(misroute[i]);
        end
    end

    // Saturating drop and misroute counters
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            drop_count_o     <= '0;
            misroute_count_o <= '0;
        end else begin
            drop_count_o     <= drop_sum[cw] ? '1 : drop_sum[cw-1:0];
            misroute_count_o <= mis_sum[cw] ? '1 : mis_sum[cw-1:0];
        end

    assign busy_o = !(&empty) || |out_vld;

endmodule
